// File: rtl/fast_sched_pkg.sv
// Shared types and widths for the FAST detector frame scheduler.
package fast_sched_pkg;

    localparam int unsigned PIX_CNT_W = 20;
    localparam int unsigned CYC_CNT_W = 21;
    localparam int unsigned ID_W      = 2;
    localparam int unsigned PIX_W     = 8;
    localparam int unsigned COORD_W   = 10;
    localparam int unsigned SCORE_W   = 8;
    localparam int unsigned TO_CNT_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STREAM   = 3'd1,
        ST_WAIT_END = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Tagged keypoint payload handed to the descriptor stage.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [SCORE_W-1:0] score;
        logic [ID_W-1:0]    src;
    } kp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer.
module rr_arbiter
    import fast_sched_pkg::*;
#(
    parameter int unsigned N_SRC = 2
) (
    input  logic [N_SRC-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_SRC-1:0] grant_c,
    output logic [ID_W-1:0]  id_c,
    output logic             any_c
);

    // Search ptr..N_SRC-1 first, then wrap to 0..ptr-1.
    always_comb begin
        grant_c = '0;
        id_c    = '0;
        any_c   = 1'b0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (!any_c && req[k] && (k >= 32'(ptr))) begin
                grant_c[k] = 1'b1;
                id_c       = ID_W'(k);
                any_c      = 1'b1;
            end
        end
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (!any_c && req[k]) begin
                grant_c[k] = 1'b1;
                id_c       = ID_W'(k);
                any_c      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fast_frame_scheduler.sv
// Frame-granular scheduler sharing one FAST detector between N_SRC pixel sources.
module fast_frame_scheduler
    import fast_sched_pkg::*;
#(
    parameter int unsigned WIDTH       = 640,
    parameter int unsigned HEIGHT      = 480,
    parameter int unsigned N_SRC       = 2,
    parameter int unsigned KP_LATENCY  = 1930,
    parameter int unsigned BORDER      = 3,
    parameter int unsigned END_TIMEOUT = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_SRC-1:0]       i_req,
    input  logic [PIX_W*N_SRC-1:0] i_pix,
    input  logic [N_SRC-1:0]       i_pix_valid,
    output logic [N_SRC-1:0]       o_src_ready,
    output logic                   o_det_start,
    output logic [7:0]             o_det_pixel,
    input  logic                   i_det_end,
    input  logic                   i_det_flag,
    input  logic [7:0]             i_det_score,
    output logic                   o_kp_valid,
    output logic [9:0]             o_kp_x,
    output logic [9:0]             o_kp_y,
    output logic [7:0]             o_kp_score,
    output logic [1:0]             o_kp_src,
    output logic                   o_frame_done,
    output logic [1:0]             o_done_src,
    output logic                   o_busy,
    output logic                   o_underrun,
    output logic                   o_end_timeout
);

    localparam int unsigned FRAME_PIX = WIDTH * HEIGHT;
    localparam logic [PIX_CNT_W-1:0] LAST_PIX  = PIX_CNT_W'(FRAME_PIX - 1);
    localparam logic [PIX_CNT_W-1:0] FRAME_END = PIX_CNT_W'(FRAME_PIX);
    localparam logic [CYC_CNT_W-1:0] LAT       = CYC_CNT_W'(KP_LATENCY);
    localparam logic [COORD_W-1:0]   X_LAST    = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0]   X_LO      = COORD_W'(BORDER);
    localparam logic [COORD_W-1:0]   X_HI      = COORD_W'(WIDTH - BORDER);
    localparam logic [COORD_W-1:0]   Y_LO      = COORD_W'(BORDER);
    localparam logic [COORD_W-1:0]   Y_HI      = COORD_W'(HEIGHT - BORDER);
    localparam logic [TO_CNT_W-1:0]  TO_LAST   = TO_CNT_W'(END_TIMEOUT - 1);

    state_t               state_q, state_d;
    logic                 grant_load, end_timeout_set;
    logic [ID_W-1:0]      g_q, ptr_q;
    logic [PIX_CNT_W-1:0] pix_cnt_q, tag_cnt_q;
    logic [CYC_CNT_W-1:0] cyc_q;
    logic [COORD_W-1:0]   tag_x_q, tag_y_q;
    logic [TO_CNT_W-1:0]  to_cnt_q;
    kp_t                  kp_q;

    logic [N_SRC-1:0]     arb_grant;
    logic [ID_W-1:0]      arb_id;
    logic                 arb_any;
    logic [PIX_W-1:0]     sel_pix;
    logic                 sel_valid;
    logic                 frame_active, tag_live, in_border, kp_hit;

    rr_arbiter #(.N_SRC(N_SRC)) u_arb (
        .req     (i_req),
        .ptr     (ptr_q),
        .grant_c (arb_grant),
        .id_c    (arb_id),
        .any_c   (arb_any)
    );

    // Pixel and valid of the currently granted source.
    always_comb begin
        sel_pix   = '0;
        sel_valid = 1'b0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (g_q == ID_W'(k)) begin
                sel_pix   = i_pix[PIX_W*k +: PIX_W];
                sel_valid = i_pix_valid[k];
            end
        end
    end

    // Detector pixel must coincide with the ready cycle, so it is a mux of registered control.
    assign o_det_pixel = (state_q == ST_STREAM && sel_valid) ? sel_pix : '0;

    // Tag position tracking and border/window qualification of detector flags.
    always_comb begin
        frame_active = (state_q == ST_STREAM) || (state_q == ST_WAIT_END) || (state_q == ST_DRAIN);
        tag_live     = frame_active && (cyc_q >= LAT) && (tag_cnt_q < FRAME_END);
        in_border    = (tag_x_q < X_LO) || (tag_x_q >= X_HI) || (tag_y_q < Y_LO) || (tag_y_q >= Y_HI);
        kp_hit       = i_det_flag && tag_live && !in_border;
    end

    // Next-state logic.
    always_comb begin
        state_d         = state_q;
        grant_load      = 1'b0;
        end_timeout_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    state_d    = ST_STREAM;
                    grant_load = 1'b1;
                end
            end
            ST_STREAM: begin
                if (pix_cnt_q == LAST_PIX) state_d = ST_WAIT_END;
            end
            ST_WAIT_END: begin
                if (i_det_end) begin
                    state_d = ST_DRAIN;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d         = ST_DRAIN;
                    end_timeout_set = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (tag_cnt_q == FRAME_END) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Grant, pointer, counters and registered control outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            g_q           <= '0;
            ptr_q         <= '0;
            pix_cnt_q     <= '0;
            cyc_q         <= '0;
            to_cnt_q      <= '0;
            o_src_ready   <= '0;
            o_det_start   <= 1'b0;
            o_busy        <= 1'b0;
            o_frame_done  <= 1'b0;
            o_done_src    <= '0;
            o_underrun    <= 1'b0;
            o_end_timeout <= 1'b0;
        end else begin
            o_det_start  <= grant_load;
            o_busy       <= (state_d != ST_IDLE);
            o_frame_done <= (state_d == ST_DONE);
            o_done_src   <= (state_d == ST_DONE) ? g_q : '0;

            if (grant_load)                o_src_ready <= arb_grant;
            else if (state_d != ST_STREAM) o_src_ready <= '0;

            if (grant_load) g_q <= arb_id;

            if (state_q == ST_DONE)
                ptr_q <= (g_q == ID_W'(N_SRC - 1)) ? '0 : g_q + ID_W'(1);

            if (grant_load)                                o_underrun <= 1'b0;
            else if (state_q == ST_STREAM && !sel_valid)   o_underrun <= 1'b1;

            if (grant_load)           o_end_timeout <= 1'b0;
            else if (end_timeout_set) o_end_timeout <= 1'b1;

            if (grant_load)                pix_cnt_q <= '0;
            else if (state_q == ST_STREAM) pix_cnt_q <= pix_cnt_q + PIX_CNT_W'(1);

            if (state_q != ST_WAIT_END) to_cnt_q <= '0;
            else                        to_cnt_q <= to_cnt_q + TO_CNT_W'(1);

            // Saturates at the latency; only the crossing matters.
            if (grant_load)                      cyc_q <= '0;
            else if (frame_active && cyc_q < LAT) cyc_q <= cyc_q + CYC_CNT_W'(1);
        end
    end

    // Raster position of the pixel whose detector result is arriving now.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tag_cnt_q <= '0;
            tag_x_q   <= '0;
            tag_y_q   <= '0;
        end else if (grant_load) begin
            tag_cnt_q <= '0;
            tag_x_q   <= '0;
            tag_y_q   <= '0;
        end else if (tag_live) begin
            tag_cnt_q <= tag_cnt_q + PIX_CNT_W'(1);
            if (tag_x_q == X_LAST) begin
                tag_x_q <= '0;
                tag_y_q <= tag_y_q + COORD_W'(1);
            end else begin
                tag_x_q <= tag_x_q + COORD_W'(1);
            end
        end
    end

    // Registered keypoint output; payload held until the next accepted flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_kp_valid <= 1'b0;
            kp_q       <= '0;
        end else begin
            o_kp_valid <= kp_hit;
            if (kp_hit) begin
                kp_q.x     <= tag_x_q;
                kp_q.y     <= tag_y_q;
                kp_q.score <= i_det_score;
                kp_q.src   <= g_q;
            end
        end
    end

    assign o_kp_x     = kp_q.x;
    assign o_kp_y     = kp_q.y;
    assign o_kp_score = kp_q.score;
    assign o_kp_src   = kp_q.src;

endmodule

// File: doc/fast_frame_scheduler.md
Name: fast_frame_scheduler

Overview:
Frame-granular scheduler that shares one FAST_Detector (FAST-9 + NMS pipeline, non-stallable) between N_SRC pixel sources (e.g. stereo cameras).
- Round-robin arbitration per frame.
- Streams the granted frame uninterrupted, starting with a 1-cycle start pulse.
- Flushes the detector pipeline with zeros.
- Tags detector keypoint flags with X/Y coordinates, score and source ID; suppresses border responses.
- Sits between the pixel sources and the descriptor/matching stage.

Parameters:
- WIDTH, 640: frame width in pixels.
- HEIGHT, 480: frame height in pixels.
- N_SRC, 2: number of requesting sources (2..4).
- KP_LATENCY, 1930: cycles from a pixel entering the detector to the detector's flag/score for that pixel as centre.
- BORDER, 3: keypoints with x<BORDER, x>=WIDTH-BORDER, y<BORDER or y>=HEIGHT-BORDER are dropped.
- END_TIMEOUT, 4: extra cycles allowed for i_det_end after the last pixel.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_req  in  N_SRC  per-source frame request (level).
- i_pix  in  8*N_SRC  per-source pixel; source k occupies bits [8k+7:8k].
- i_pix_valid  in  N_SRC  per-source pixel valid.
- o_src_ready  out  N_SRC  one-hot; granted source must supply a pixel this cycle.
- o_det_start  out  1  1-cycle pulse to the detector, coincident with pixel 0.
- o_det_pixel  out  8  pixel to the detector.
- i_det_end  in  1  detector end pulse.
- i_det_flag  in  1  detector keypoint flag (post-NMS).
- i_det_score  in  8  detector score.
- o_kp_valid  out  1  tagged keypoint valid.
- o_kp_x  out  10  keypoint column.
- o_kp_y  out  10  keypoint row.
- o_kp_score  out  8  keypoint score.
- o_kp_src  out  2  source ID of the keypoint.
- o_frame_done  out  1  1-cycle pulse at end of the frame's drain.
- o_done_src  out  2  source ID qualified by o_frame_done.
- o_busy  out  1  high in any state other than IDLE.
- o_underrun  out  1  sticky; granted source had valid low while ready high. Cleared on the next grant.
- o_end_timeout  out  1  sticky; i_det_end missing. Cleared on the next grant.

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer 0; all counters 0.
- Reset asserted mid-frame: immediate abort; no o_frame_done for that frame.
- States and transitions:
  - IDLE: if any i_req, grant the first requester at or after the pointer (registered) and go to STREAM. With no request, stay in IDLE.
  - STREAM:
    - o_src_ready[g]=1 and o_det_pixel = i_pix of source g; on underrun, o_det_pixel=0.
    - o_det_start=1 only on the first STREAM cycle.
    - Pixel counter p runs 0..WIDTH*HEIGHT-1; after p=WIDTH*HEIGHT-1, go to WAIT_END.
  - WAIT_END: o_det_pixel=0. On i_det_end, go to DRAIN. If END_TIMEOUT cycles pass without i_det_end, set o_end_timeout and go to DRAIN.
  - DRAIN: o_det_pixel=0; stay until the tag counter reaches WIDTH*HEIGHT, then go to DONE.
  - DONE: pulse o_frame_done with o_done_src=g; pointer = g+1 mod N_SRC; return to IDLE. Next grant is earliest the following cycle.
- Request handling: i_req is ignored while not IDLE. Dropping i_req mid-frame does not abort the frame.
- Tagging:
  - Tag counter t = (cycles since o_det_start) - KP_LATENCY, tracked as (x,y) with x wrapping at WIDTH and incrementing y.
  - Valid window is 0 <= t < WIDTH*HEIGHT.
  - o_kp_valid is registered, 1 cycle after i_det_flag, when i_det_flag=1, t is inside the window, and (x,y) is outside the border band.
  - o_kp_x, o_kp_y, o_kp_score, o_kp_src are held with o_kp_valid.
  - A flag outside the window or inside the border band is dropped silently.
- Widths:
  - Pixel and tag counters are 20 bits (WIDTH*HEIGHT <= 2^20).
  - Cycle-since-start counter is 21 bits.
  - o_kp_src and o_done_src are zero-extended to 2 bits.

Decomposition:
- Package fast_sched_pkg: state encoding (IDLE, STREAM, WAIT_END, DRAIN, DONE), counter widths, ID width.
- One sub-module rr_arbiter: N_SRC request vector + pointer -> one-hot grant + encoded ID; combinational, registered by the parent.

Test Plan:
(WIDTH=16, HEIGHT=8, KP_LATENCY=10, BORDER=3, END_TIMEOUT=4)
- Single source: i_req=01 with a valid ramp -> o_det_start once, 128 pixels streamed, o_frame_done with o_done_src=0 after DRAIN, o_busy low afterwards.
- Both sources request continuously -> grant order 0,1,0,1; no overlap of o_src_ready; pixels of frame k come only from the granted source.
- i_det_flag at cycle start+10+(4*16+5) with score 0x55 -> o_kp_valid with x=5, y=4, score=0x55, src=granted. Flag at x=1 or y=7 -> no o_kp_valid.
- i_pix_valid low for 3 STREAM cycles -> o_det_pixel=0 on those cycles, o_underrun=1 until the next grant, frame still completes.
- i_det_end never asserted -> o_end_timeout=1 after 4 cycles in WAIT_END; DRAIN and DONE proceed normally.
- i_rst_n low mid-STREAM -> all outputs 0 immediately; after release, a fresh request starts at source 0 with o_det_start.
